// File: rtl/spi_responder.sv
// spi_responder: SPI mode-0 slave, MSB first, DATA_WIDTH-bit full-duplex frames.
// The SPI inputs are oversampled in the clk_i domain. Local logic sees a receive
// register (valid/ack) and a one-entry transmit buffer.
//
// Ports:
//   clk_i, reset_i         system clock, synchronous active-high reset
//   spi_clk_i, mosi_i,     SPI bus from the master (asynchronous to clk_i)
//   ss_n_i
//   miso_o, miso_oe_o      serial data to the master and its tri-state enable
//   rx_data_o, rx_valid_o, received frame, valid flag and consume strobe
//   rx_ack_i
//   overrun_o              sticky: a frame arrived with no room for it
//   tx_data_i, tx_ld_i,    transmit buffer write port and "buffer free" flag
//   tx_empty_o
//   underrun_o             sticky: a frame started with an empty tx buffer
//   busy_o                 frame in progress
//
// Optional feature: define SPI_RESPONDER_RXFIFO_EN for a 4-deep receive FIFO
// in place of the single overwriting receive register.

module spi_responder #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  spi_clk_i,
    input  logic                  mosi_i,
    input  logic                  ss_n_i,
    output logic                  miso_o,
    output logic                  miso_oe_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_valid_o,
    input  logic                  rx_ack_i,
    output logic                  overrun_o,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    input  logic                  tx_ld_i,
    output logic                  tx_empty_o,
    output logic                  underrun_o,
    output logic                  busy_o
);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_e;

    // synchronizers, history flops and post-reset arming
    logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, ss_sync_q, warm_q;
    logic                   sclk_hist_q, ss_hist_q, armed_q;
    logic                   sclk_s, mosi_s, ss_s;
    logic                   sclk_rise, sclk_fall, ss_fall, ss_rise;

    state_e                 state_q, state_d;
    logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]  tx_shift_q, tx_shift_d, tx_buf_q, tx_buf_d;
    logic [DATA_WIDTH-1:0]  rx_shift_q, rx_shift_d, load_val, frame_word;
    logic                   tx_empty_q, tx_empty_d, underrun_q, underrun_d;
    logic                   miso_q, miso_d, oe_q, oe_d, overrun_q;
    logic                   consume, frame_done, sticky_clr;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign ss_s      = ss_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_hist_q;
    assign sclk_fall = ~sclk_s & sclk_hist_q;
    assign ss_rise   = ss_s & ~ss_hist_q;
    // A select already low when reset is released must not start a frame;
    // the slave arms only once the synchronized ss_n has been seen high.
    assign ss_fall   = armed_q & ss_hist_q & ~ss_s;

    assign load_val   = tx_empty_q ? '0 : tx_buf_q;
    assign frame_word = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
    assign sticky_clr = rx_ack_i & rx_valid_o;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        tx_shift_d = tx_shift_q;
        tx_buf_d   = tx_buf_q;
        tx_empty_d = tx_empty_q;
        rx_shift_d = rx_shift_q;
        miso_d     = miso_q;
        oe_d       = oe_q;
        consume    = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            IDLE: begin
                oe_d   = 1'b0;
                miso_d = 1'b0;
                if (ss_fall) state_d = LOAD;
            end
            LOAD: begin
                consume    = 1'b1;
                tx_shift_d = load_val;
                bit_cnt_d  = '0;
                oe_d       = 1'b1;
                miso_d     = load_val[DATA_WIDTH-1];
                state_d    = SHIFT;
            end
            SHIFT: begin
                if (sclk_rise) begin
                    rx_shift_d = frame_word;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d  = '0;
                        frame_done = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end
                end else if (sclk_fall) begin
                    if (bit_cnt_q != '0) begin
                        tx_shift_d = tx_shift_q << 1;
                        miso_d     = tx_shift_q[DATA_WIDTH-2];
                    end else begin
                        // frame boundary: next frame's data comes from the buffer
                        consume    = 1'b1;
                        tx_shift_d = load_val;
                        miso_d     = load_val[DATA_WIDTH-1];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (ss_rise) begin
            state_d    = IDLE;
            oe_d       = 1'b0;
            bit_cnt_d  = '0;
            frame_done = 1'b0;
        end
        if (consume) tx_empty_d = 1'b1;
        // a write is taken when the buffer is free or being consumed right now
        if (tx_ld_i && (tx_empty_q || consume)) begin
            tx_buf_d   = tx_data_i;
            tx_empty_d = 1'b0;
        end
        underrun_d = (underrun_q & ~sticky_clr) | (consume & tx_empty_q);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            ss_sync_q   <= '1;
            warm_q      <= '0;
            sclk_hist_q <= 1'b0;
            ss_hist_q   <= 1'b1;
            armed_q     <= 1'b0;
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            tx_shift_q  <= '0;
            tx_buf_q    <= '0;
            tx_empty_q  <= 1'b1;
            underrun_q  <= 1'b0;
            rx_shift_q  <= '0;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_n_i};
            warm_q      <= {warm_q[SYNC_STAGES-2:0], 1'b1};
            sclk_hist_q <= sclk_s;
            ss_hist_q   <= ss_s;
            // once warm_q is full, ss_s reflects post-reset input only
            armed_q     <= armed_q | (warm_q[SYNC_STAGES-1] & ss_s);
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_shift_q  <= tx_shift_d;
            tx_buf_q    <= tx_buf_d;
            tx_empty_q  <= tx_empty_d;
            underrun_q  <= underrun_d;
            rx_shift_q  <= rx_shift_d;
            miso_q      <= miso_d;
            oe_q        <= oe_d;
        end
    end

`ifdef SPI_RESPONDER_RXFIFO_EN
    logic [DATA_WIDTH-1:0] fifo_q [4];
    logic [2:0]            wptr_q, rptr_q;
    logic                  fifo_empty, fifo_full, push, pop;

    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_full  = (wptr_q[2] != rptr_q[2]) && (wptr_q[1:0] == rptr_q[1:0]);
    assign pop        = rx_ack_i & ~fifo_empty;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    assign push       = frame_done & (~fifo_full | pop);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (push) begin
                fifo_q[wptr_q[1:0]] <= frame_word;
                wptr_q              <= wptr_q + 3'd1;
            end
            if (pop) rptr_q <= rptr_q + 3'd1;
            overrun_q <= (overrun_q & ~sticky_clr) | (frame_done & fifo_full & ~pop);
        end
    end

    assign rx_data_o  = fifo_q[rptr_q[1:0]];
    assign rx_valid_o = ~fifo_empty;
`else
    logic [DATA_WIDTH-1:0] rx_data_q;
    logic                  rx_valid_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            if (frame_done) begin
                rx_data_q  <= frame_word;
                rx_valid_q <= 1'b1;
            end else if (rx_ack_i) begin
                rx_valid_q <= 1'b0;
            end
            // an ack in the completion cycle makes room: no overrun
            overrun_q <= (overrun_q & ~sticky_clr) | (frame_done & rx_valid_q & ~rx_ack_i);
        end
    end

    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
`endif

    assign miso_o     = miso_q;
    assign miso_oe_o  = oe_q;
    assign overrun_o  = overrun_q;
    assign tx_empty_o = tx_empty_q;
    assign underrun_o = underrun_q;
    assign busy_o     = (state_q == SHIFT) && (bit_cnt_q != '0);

endmodule

// File: tb/tb_spi_responder.sv
// Self-checking bench for spi_responder: the bench acts as SPI master
// (spi_clk = clk_i/8). Expected master-received bytes and expected received
// frames are queued when a transfer is driven and popped when the data appears.

module tb_spi_responder;
    logic       clk_i = 1'b0;
    logic       reset_i, spi_clk_i, mosi_i, ss_n_i;
    logic       miso_o, miso_oe_o, rx_valid_o, rx_ack_i, overrun_o;
    logic [7:0] rx_data_o, tx_data_i;
    logic       tx_ld_i, tx_empty_o, underrun_o, busy_o;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_miso_q[$];
    logic [7:0] exp_rx_q[$];

    spi_responder #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .spi_clk_i(spi_clk_i), .mosi_i(mosi_i),
        .ss_n_i(ss_n_i), .miso_o(miso_o), .miso_oe_o(miso_oe_o), .rx_data_o(rx_data_o),
        .rx_valid_o(rx_valid_o), .rx_ack_i(rx_ack_i), .overrun_o(overrun_o),
        .tx_data_i(tx_data_i), .tx_ld_i(tx_ld_i), .tx_empty_o(tx_empty_o),
        .underrun_o(underrun_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic select();
        ss_n_i = 1'b0;
        cyc(6);
    endtask

    task automatic deselect();
        ss_n_i = 1'b1;
        cyc(6);
    endtask

    task automatic tx_load(input logic [7:0] d);
        tx_data_i = d;
        tx_ld_i   = 1'b1;
        cyc(1);
        tx_ld_i   = 1'b0;
    endtask

    task automatic ack();
        rx_ack_i = 1'b1;
        cyc(1);
        rx_ack_i = 1'b0;
        cyc(1);
    endtask

    // shift nb bits MSB first; miso sampled just before each rising edge
    task automatic spi_bits(input logic [7:0] d, input int nb, output logic [7:0] r);
        r = '0;
        for (int i = 0; i < nb; i++) begin
            mosi_i = d[7-i];
            cyc(4);
            r = {r[6:0], miso_o};
            spi_clk_i = 1'b1;
            cyc(4);
            spi_clk_i = 1'b0;
        end
        cyc(4);
    endtask

    task automatic xfer(input string tag, input logic [7:0] mtx, input logic [7:0] exp_m);
        logic [7:0] r;
        exp_miso_q.push_back(exp_m);
        exp_rx_q.push_back(mtx);
        spi_bits(mtx, 8, r);
        chk({tag, "_miso"}, {24'd0, r}, {24'd0, exp_miso_q.pop_front()});
    endtask

    // wait (bounded) for a received frame and compare it with the queue head
    task automatic rx_pop(input string tag);
        int t = 0;
        while (!rx_valid_o && t < 100) begin
            cyc(1);
            t++;
        end
        if (!rx_valid_o) chk({tag, "_timeout"}, 32'd0, 32'd1);
        else if (exp_rx_q.size() == 0) chk({tag, "_unexpected"}, 32'd1, 32'd0);
        else chk({tag, "_rxdata"}, {24'd0, rx_data_o}, {24'd0, exp_rx_q.pop_front()});
    endtask

    initial begin
        logic [7:0] r;
        reset_i = 1'b1; spi_clk_i = 1'b0; mosi_i = 1'b0; ss_n_i = 1'b1;
        rx_ack_i = 1'b0; tx_data_i = '0; tx_ld_i = 1'b0;
        cyc(3);
        reset_i = 1'b0;
        cyc(4);
        chk("rst_oe", miso_oe_o, 0);
        chk("rst_miso", miso_o, 0);
        chk("rst_txe", tx_empty_o, 1);
        chk("rst_rxv", rx_valid_o, 0);
        chk("rst_rxd", rx_data_o, 0);
        chk("rst_flags", {overrun_o, underrun_o, busy_o}, 0);

        // basic frame: tx A5, master sends 3C
        tx_load(8'hA5);
        chk("ld_txe", tx_empty_o, 0);
        select();
        chk("sel_oe", miso_oe_o, 1);
        chk("sel_txe", tx_empty_o, 1);
        xfer("f1", 8'h3C, 8'hA5);
        rx_pop("f1");
        chk("f1_txe", tx_empty_o, 1);
        chk("f1_ovr", overrun_o, 0);
        // trailing falling edge reloads from an empty buffer
        chk("f1_udr", underrun_o, 1);
        deselect();
        chk("desel_oe", miso_oe_o, 0);
        ack();
        chk("ack_rxv", rx_valid_o, 0);
        chk("ack_udr", underrun_o, 0);

        // back-to-back frames, no ack between them
        tx_load(8'h96);
        select();
        tx_load(8'h69);
        xfer("b2b1", 8'h11, 8'h96);
        xfer("b2b2", 8'h22, 8'h69);
        deselect();
`ifdef SPI_RESPONDER_RXFIFO_EN
        rx_pop("b2b_pop1");
        chk("b2b_ovr", overrun_o, 0);
        ack();
        rx_pop("b2b_pop2");
        ack();
`else
        void'(exp_rx_q.pop_front());  // 0x11 is overwritten by 0x22
        rx_pop("b2b");
        chk("b2b_ovr", overrun_o, 1);
        ack();
        chk("b2b_ovr_clr", overrun_o, 0);
`endif
        chk("b2b_rxv", rx_valid_o, 0);

        // underrun: frame started with an empty buffer
        select();
        chk("udr_set", underrun_o, 1);
        xfer("udr", 8'h77, 8'h00);
        deselect();
        rx_pop("udr");
        ack();
        chk("udr_clr", underrun_o, 0);

        // partial frame discarded on deselect
        select();
        spi_bits(8'hFF, 5, r);
        chk("part_busy", busy_o, 1);
        deselect();
        chk("part_rxv", rx_valid_o, 0);
        chk("part_oe", miso_oe_o, 0);
        chk("part_busy_off", busy_o, 0);
        tx_load(8'hC3);
        select();
        xfer("f81", 8'h81, 8'hC3);
        deselect();
        rx_pop("f81");
        ack();

        // reset mid-frame with ss_n held low
        select();
        tx_load(8'h5C);
        spi_bits(8'hF0, 4, r);
        reset_i = 1'b1;
        cyc(2);
        reset_i = 1'b0;
        cyc(1);
        chk("mrst_oe", miso_oe_o, 0);
        chk("mrst_txe", tx_empty_o, 1);
        chk("mrst_busy", busy_o, 0);
        spi_bits(8'hAA, 8, r);
        chk("mrst_nostart_rxv", rx_valid_o, 0);
        chk("mrst_nostart_oe", miso_oe_o, 0);
        chk("mrst_flags", {overrun_o, underrun_o}, 0);
        deselect();
        select();
        xfer("f5a", 8'h5A, 8'h00);
        deselect();
        rx_pop("f5a");
        ack();
        chk("sb_empty", exp_rx_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
